// File: rtl/data_bus_pkg.sv
// Shared definitions for the data bus: transfer mode encodings and the arbiter FSM states.
// Later peripherals on the bus import the mode constants from here.
package data_bus_pkg;

  localparam logic [1:0] MODE_NONE    = 2'b00;
  localparam logic [1:0] MODE_READ    = 2'b01;
  localparam logic [1:0] MODE_WRITE   = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  localparam int LOCK_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // Illegal requests never reach the peripherals; they appear as an empty cycle.
  function automatic logic [1:0] bus_mode(input logic [1:0] mode);
    return (mode == MODE_ILLEGAL) ? MODE_NONE : mode;
  endfunction

endpackage

// File: rtl/data_bus_arbiter_arb_pick.sv
// Winner selection for the two-master data bus arbiter.
// DATA_BUS_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise master 0 always wins ties.
module arb_pick (
  input  logic [1:0] req,
`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
  input  logic       ptr,
`endif
  output logic       valid,
  output logic       idx
);

  assign valid = |req;

`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
  // ptr names the master granted last, so the other one takes a tie.
  always_comb begin
    idx = req[1];
    if (req == 2'b11) begin
      idx = ~ptr;
    end
  end
`else
  assign idx = req[1] & ~req[0];
`endif

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter and sequencer for the shared single-cycle data bus.
// Optional DATA_BUS_ARB_ROUND_ROBIN_EN enables round-robin tie breaking (default: fixed priority).
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m0_mode,
  input  logic [1:0]  m1_mode,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_done,
  output logic        m1_done,
  output logic [31:0] data_bus_addr,
  output logic [1:0]  data_bus_mode,
  inout  wire  [31:0] data_bus_data
);

  // state | meaning
  // IDLE  | bus quiet; regrant a locked owner or arbitrate between requesters
  // BUS   | one bus cycle for the owner; read data captured at the closing edge
  // DONE  | owner's done pulse; bus quiet

  localparam logic [LOCK_CNT_W-1:0] LOCK_LIM = LOCK_CNT_W'(LOCK_MAX);

  arb_state_e            state, state_nxt;
  logic                  owner, owner_nxt;
  logic                  lock_q, lock_nxt;
  logic [LOCK_CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic                  grant;
  logic                  regrant_ok;

  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;
  logic [1:0]            cur_mode;

  logic [1:0]            req_vec;
  logic                  pick_valid;
  logic                  pick_idx;

  assign req_vec = {m1_req, m0_req};

`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  arb_pick u_pick (
    .req   (req_vec),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 1'b1;
    end else if (state == IDLE && !regrant_ok && pick_valid) begin
      rr_ptr <= pick_idx;
    end
  end
`else
  arb_pick u_pick (
    .req   (req_vec),
    .valid (pick_valid),
    .idx   (pick_idx)
  );
`endif

  // A lock only carries over into the first IDLE cycle after DONE; any
  // grant or an empty IDLE cycle overwrites lock_q.
  assign regrant_ok = lock_q && (lock_cnt < LOCK_LIM) && req_vec[owner];

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    lock_nxt     = lock_q;
    lock_cnt_nxt = lock_cnt;
    grant        = 1'b0;
    case (state)
      IDLE: begin
        if (regrant_ok) begin
          grant        = 1'b1;
          lock_cnt_nxt = lock_cnt + 1'b1;
          state_nxt    = BUS;
        end else if (pick_valid) begin
          grant        = 1'b1;
          owner_nxt    = pick_idx;
          lock_cnt_nxt = '0;
          state_nxt    = BUS;
        end else begin
          lock_nxt = 1'b0;
        end
        if (grant) begin
          lock_nxt = owner_nxt ? m1_lock : m0_lock;
        end
      end
      BUS:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      lock_q   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      lock_q   <= lock_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // The granted request is latched so a misbehaving master cannot disturb its own bus cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_mode  <= MODE_NONE;
    end else if (grant) begin
      cur_addr  <= owner_nxt ? m1_addr  : m0_addr;
      cur_wdata <= owner_nxt ? m1_wdata : m0_wdata;
      cur_mode  <= owner_nxt ? m1_mode  : m0_mode;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == BUS) begin
      if (cur_mode == MODE_READ) begin
        if (owner) m1_rdata <= data_bus_data;
        else       m0_rdata <= data_bus_data;
      end else if (cur_mode == MODE_ILLEGAL) begin
        if (owner) m1_rdata <= '0;
        else       m0_rdata <= '0;
      end
    end
  end

  assign data_bus_addr = (state == BUS) ? cur_addr : '0;
  assign data_bus_mode = (state == BUS) ? bus_mode(cur_mode) : MODE_NONE;
  assign data_bus_data = (state == BUS && cur_mode == MODE_WRITE) ? cur_wdata : 'z;

  assign m0_done = (state == DONE) && !owner;
  assign m1_done = (state == DONE) && owner;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed scenarios plus random traffic against a transaction-schedule model.
// Honours DATA_BUS_ARB_ROUND_ROBIN_EN the same way as the design build.
module tb_data_bus_arbiter;

  localparam int LOCK_MAX = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req [2];
  logic        lock [2];
  logic [31:0] addr [2];
  logic [1:0]  mode [2];
  logic [31:0] wdata [2];
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m1_done;
  logic [31:0] data_bus_addr;
  logic [1:0]  data_bus_mode;
  wire  [31:0] data_bus_data;
  logic [31:0] tick_count;
  logic        bus_hiz;

  always #5 clk = ~clk;

  data_bus_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk           (clk),
    .reset         (reset),
    .m0_req        (req[0]),
    .m1_req        (req[1]),
    .m0_lock       (lock[0]),
    .m1_lock       (lock[1]),
    .m0_addr       (addr[0]),
    .m1_addr       (addr[1]),
    .m0_mode       (mode[0]),
    .m1_mode       (mode[1]),
    .m0_wdata      (wdata[0]),
    .m1_wdata      (wdata[1]),
    .m0_rdata      (m0_rdata),
    .m1_rdata      (m1_rdata),
    .m0_done       (m0_done),
    .m1_done       (m1_done),
    .data_bus_addr (data_bus_addr),
    .data_bus_mode (data_bus_mode),
    .data_bus_data (data_bus_data)
  );

  // Peripheral: systick at 0x4010 returns tick_count, other addresses a fixed pattern.
  function automatic logic [31:0] periph(input logic [31:0] a, input logic [31:0] tc);
    return (a == 32'h4010) ? tc : {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  assign data_bus_data = (data_bus_mode == 2'b01) ? periph(data_bus_addr, tick_count) : 32'bz;
  assign bus_hiz = (data_bus_data === 32'bz);

  int n_checks = 0;
  int n_errors = 0;

  // Model: one scheduled transaction with its bus and done cycles.
  int          cyc = 0;
  int          bus_cyc, done_cyc, next_arb, streak, last_done_cyc;
  bit          t_owner, last_lock, rr_last;
  logic [31:0] t_addr, t_wdata, t_rval;
  logic [1:0]  t_mode;
  logic [31:0] exp_rd [2];
  bit          hold [2];
  bit          auto_en;
  int          p_start, p_keep, p_lock;
  int          done_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    bus_cyc   = -10;
    done_cyc  = -10;
    next_arb  = cyc;
    streak    = 0;
    last_lock = 1'b0;
    rr_last   = 1'b1;
    t_owner   = 1'b0;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
  endtask

  task automatic reset_checks();
    chk("rst_addr", data_bus_addr, 32'h0);
    chk("rst_mode", 32'(data_bus_mode), 32'h0);
    chk("rst_hiz", 32'(bus_hiz), 32'h1);
    chk("rst_m0_done", 32'(m0_done), 32'h0);
    chk("rst_m1_done", 32'(m1_done), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
  endtask

  task automatic rand_txn(input int i);
    int r;
    r = $urandom_range(0, 3);
    addr[i]  = (r == 0) ? 32'h4010 : $urandom;
    mode[i]  = 2'($urandom_range(0, 3));
    wdata[i] = $urandom;
    lock[i]  = ($urandom_range(0, 99) < p_lock);
  endtask

  task automatic set_txn(input int i, input logic [31:0] a, input logic [1:0] m,
                         input logic [31:0] d, input bit lk, input bit hd);
    addr[i]  = a;
    mode[i]  = m;
    wdata[i] = d;
    lock[i]  = lk;
    hold[i]  = hd;
    req[i]   = 1'b1;
  endtask

  // Sample the cycle at its negedge, then let the master that just finished react.
  task automatic tick();
    bit          in_bus, in_done;
    logic [31:0] ea;
    logic [1:0]  em;
    @(negedge clk);
    cyc++;
    in_bus  = (cyc == bus_cyc);
    in_done = (cyc == done_cyc);
    ea = in_bus ? t_addr : 32'h0;
    em = (in_bus && t_mode != 2'b11) ? t_mode : 2'b00;
    chk("bus_addr", data_bus_addr, ea);
    chk("bus_mode", 32'(data_bus_mode), 32'(em));
    if (in_bus && t_mode == 2'b10)
      chk("bus_wdata", data_bus_data, t_wdata);
    else if (!(in_bus && t_mode == 2'b01))
      chk("bus_hiz", 32'(bus_hiz), 32'h1);
    chk("m0_done", 32'(m0_done), 32'(in_done && !t_owner));
    chk("m1_done", 32'(m1_done), 32'(in_done && t_owner));
    if (in_bus && t_mode == 2'b01) t_rval = periph(t_addr, tick_count);
    if (in_done) begin
      if (t_mode == 2'b01) exp_rd[t_owner] = t_rval;
      else if (t_mode == 2'b11) exp_rd[t_owner] = 32'h0;
      chk("m0_rdata", m0_rdata, exp_rd[0]);
      chk("m1_rdata", m1_rdata, exp_rd[1]);
      done_log.push_back(int'(t_owner));
      last_done_cyc = cyc;
      if (auto_en) begin
        if ($urandom_range(0, 99) < p_keep) rand_txn(int'(t_owner));
        else req[t_owner] = 1'b0;
      end else if (!hold[t_owner]) begin
        req[t_owner] = 1'b0;
      end
    end
  endtask

  // Arbitration rules applied to the requests present at the closing edge of this cycle.
  task automatic settle();
    bit win, regrant;
    if (auto_en)
      for (int i = 0; i < 2; i++)
        if (!req[i] && $urandom_range(0, 99) < p_start) begin
          rand_txn(i);
          req[i] = 1'b1;
        end
    if (cyc < next_arb || !(req[0] || req[1])) return;
    regrant = (cyc == next_arb) && last_lock && (streak < LOCK_MAX) && req[t_owner];
    if (regrant) begin
      win = t_owner;
      streak++;
    end else begin
      if (req[0] && req[1]) begin
`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
        win = ~rr_last;
`else
        win = 1'b0;
`endif
      end else begin
        win = req[1];
      end
      rr_last = win;
      streak  = 0;
    end
    t_owner   = win;
    last_lock = lock[win];
    t_addr    = addr[win];
    t_mode    = mode[win];
    t_wdata   = wdata[win];
    bus_cyc   = cyc + 1;
    done_cyc  = cyc + 2;
    next_arb  = cyc + 3;
  endtask

  task automatic step();
    tick();
    settle();
  endtask

  task automatic wait_dones(input int n, input int maxc);
    int k = 0;
    while (done_log.size() < n && k < maxc) begin
      step();
      k++;
    end
    chk("done_count", 32'(done_log.size()), 32'(n));
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((req[0] || req[1] || cyc < next_arb) && k < maxc) begin
      step();
      k++;
    end
    chk("drain_idle", 32'(req[0] | req[1]), 32'h0);
  endtask

  int g;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; lock[i] = 1'b0; addr[i] = '0; mode[i] = '0; wdata[i] = '0; hold[i] = 1'b0;
    end
    auto_en = 1'b0; p_start = 30; p_keep = 50; p_lock = 35;
    tick_count = 32'h0; last_done_cyc = 0;

    // Power-on reset
    #2 reset = 1'b0;
    #1 reset_checks();
    @(negedge clk); cyc++;
    reset = 1'b1;
    model_reset();
    settle();

    // Contention: both masters read continuously without lock
    tick();
    set_txn(0, 32'h0000_0100, 2'b01, 32'h0, 1'b0, 1'b1);
    set_txn(1, 32'h0000_0204, 2'b01, 32'h0, 1'b0, 1'b1);
    done_log.delete();
    settle();
    wait_dones(6, 60);
    if (done_log.size() >= 6)
      for (int k = 0; k < 6; k++)
`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
        chk("grant_order", 32'(done_log[k]), 32'(k % 2));
`else
        chk("grant_order", 32'(done_log[k]), 32'h0);
`endif
    hold[0] = 1'b0; hold[1] = 1'b0;
    drain(40);

    // Single systick read
    tick();
    tick_count = 32'd5;
    set_txn(0, 32'h4010, 2'b01, 32'h0, 1'b0, 1'b0);
    done_log.delete();
    settle();
    g = cyc;
    wait_dones(1, 10);
    chk("sr_rdata", m0_rdata, 32'd5);
    chk("sr_latency", 32'(last_done_cyc - g), 32'd2);
    drain(10);

    // Write drive
    tick();
    set_txn(0, 32'h4000, 2'b10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    done_log.delete();
    settle();
    wait_dones(1, 10);
    drain(10);

    // Read then illegal on master 1
    tick();
    set_txn(1, 32'h0000_0100, 2'b01, 32'h0, 1'b0, 1'b0);
    done_log.delete();
    settle();
    wait_dones(1, 10);
    chk("pre_ill_rdata", m1_rdata, periph(32'h0000_0100, tick_count));
    drain(10);
    tick();
    set_txn(1, 32'h0000_0300, 2'b11, 32'h1234_5678, 1'b0, 1'b0);
    done_log.delete();
    settle();
    wait_dones(1, 10);
    chk("ill_rdata", m1_rdata, 32'h0);
    drain(10);

    // Lock limit: m1 locked, m0 waiting
    tick();
    set_txn(1, 32'h0000_0200, 2'b01, 32'h0, 1'b1, 1'b1);
    done_log.delete();
    settle();
    tick();
    set_txn(0, 32'h0000_0300, 2'b01, 32'h0, 1'b0, 1'b1);
    settle();
    wait_dones(4, 40);
    if (done_log.size() >= 4) begin
      chk("lock_seq0", 32'(done_log[0]), 32'd1);
      chk("lock_seq1", 32'(done_log[1]), 32'd1);
      chk("lock_seq2", 32'(done_log[2]), 32'd1);
      chk("lock_seq3", 32'(done_log[3]), 32'd0);
    end
    hold[0] = 1'b0; hold[1] = 1'b0;
    drain(60);

    // Reset in the middle of a write bus cycle
    tick();
    set_txn(0, 32'h4000, 2'b10, 32'h1234_5678, 1'b0, 1'b1);
    settle();
    tick();
    #1 reset = 1'b0;
    #1 reset_checks();
    repeat (2) begin
      @(negedge clk); cyc++;
      reset_checks();
    end
    reset = 1'b1;
    model_reset();
    hold[0] = 1'b0;
    done_log.delete();
    settle();
    g = cyc;
    wait_dones(1, 10);
    if (done_log.size() >= 1) chk("rst_restart_owner", 32'(done_log[0]), 32'h0);
    chk("rst_restart_latency", 32'(last_done_cyc - g), 32'd2);
    drain(10);

    // Random traffic
    tick_count = $urandom;
    auto_en = 1'b1;
    repeat (1500) step();
    auto_en = 1'b0;
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
